vec_ctrl_seq: RTL and testbench
===============================

// Module: vec_ctrl_seq
// PURPOSE
//  Multi-beat successor to the single-cycle opcode decoder of the vector CPU.
//  - Accepts one instruction per valid/ready handshake and decodes it to ALU/memory/writeback controls.
//  - Sequences vector ops over VLEN/LANES beats, one beat per cycle, or one beat per mem_ack for memory ops.
//  - Sits between fetch/issue and the lane datapath and memory port.
// PARAMETERS
//  OPW    5  opcode width
//  VLEN   4  elements per vector register
//  LANES  2  elements processed per beat; VLEN%LANES==0 required; BEATS=VLEN/LANES
//  BW     (BEATS>1 ? $clog2(BEATS) : 1)  beat index width (localparam)
// PORTS
//  clk          in   1    clock, rising edge
//  rst_n        in   1    asynchronous reset, active-low
//  instr_valid  in   1    opcode valid from issue
//  instr_ready  out  1    block can accept an opcode this cycle
//  opcode       in   OPW  instruction opcode
//  flush        in   1    synchronous abort of the current instruction
//  mem_ack      in   1    memory completed the current ldv/stv beat
//  aluop        out  4    ALU operation for the current beat
//  memread      out  1    memory read request
//  memwrite     out  1    memory write request
//  memtoreg     out  1    writeback source is memory
//  regwrite     out  1    register/lane write enable for the current beat
//  jump         out  1    cmpj jump qualifier
//  beat_valid   out  1    control outputs are valid this cycle
//  beat_idx     out  BW   current beat number, 0..BEATS-1
//  beat_last    out  1    current beat is the final one
//  busy         out  1    instruction in flight
//  illegal      out  1    undefined opcode pulse (only with VCTRL_ILLEGAL_EN)
// BEHAVIOUR
//  Reset (rst_n=0, async):
//  - State IDLE; every output 0 except instr_ready=1; opcode register cleared.
//  States: IDLE, ALU (1 beat/cycle), MEM (beat advances only when mem_ack=1).
//  Accept: instr_valid & instr_ready & ~flush registers the opcode; first beat_valid in the next cycle (latency 1).
//  instr_ready = ~flush & (IDLE | (beat_last & beat advancing)), so back-to-back issue has no bubble.
//  Decode (aluop, mem, wr, jump, beats):
//  - 00000 nop: accepted, no beats, remains IDLE.
//  - 00100 add: 0000, wr=1, 1 beat.
//  - 00110 cmpj: 0001, wr=1, jump=1, 1 beat.
//  - 01000 eorv 0010; 01001 subv 0001; 01010 addv 0000; 01100 lslv 0011; 01101 lsrv 0100; 01110 rorv 0101; 01111 rolv 0110:
//    wr=1, BEATS beats.
//  - 10001 ldv: 0000, memread=1, memtoreg=1, regwrite=1 only in the mem_ack cycle, BEATS beats.
//  - 10010 stv: 0000, memwrite=1, regwrite=0, BEATS beats.
//  - Any other opcode: treated as nop.
//  Control outputs are registered from the opcode and are 0 whenever beat_valid=0.
//  beat_idx starts at 0 for each instruction and increments by 1 per advance; beat_last = (beat_idx==BEATS-1).
//  MEM state: memread/memwrite held steady until mem_ack; mem_ack is ignored outside MEM.
//  After the final advance with no new accept, return to IDLE with outputs 0 next cycle.
//  flush: next cycle is IDLE, all outputs 0, beat_idx 0; flush takes priority over accept and mem_ack.
//  BEATS==1: every vector op is a single beat; beat_idx is constant 0.
//  busy = (state != IDLE).
// CONFIGURATION
//  VCTRL_ILLEGAL_EN defined:
//  - illegal pulses 1 cycle, in the cycle after an undefined opcode is accepted.
//  - The opcode is still treated as nop.
//  Undefined:
//  - The illegal port is absent; undefined opcodes are silently treated as nop.
// TESTING
//  Reset mid-addv (beat 1) -> all outputs 0 immediately and instr_ready=1; fresh addv afterwards starts at beat_idx 0.
//  VLEN=4, LANES=2, addv accepted -> beats idx 0,1 in consecutive cycles, aluop=0000, regwrite=1, beat_last only on idx 1.
//  ldv with mem_ack on cycles 3 and 6 after accept -> memread held through cycle 6, regwrite=1 only in cycles 3 and 6, then IDLE.
//  stv then rolv issued back-to-back -> rolv accepted on the stv last-ack cycle; next cycle idx 0 with aluop=0110, no bubble.
//  cmpj -> one beat with aluop=0001 and jump=1; flush during beat 0 of subv -> outputs 0 next cycle, opcode not accepted.
//  Opcode 11111 with VCTRL_ILLEGAL_EN -> illegal=1 for one cycle, no beat_valid; without the macro -> no beat, stays IDLE.

Source files
------------

// File: rtl/vec_ctrl_seq_if.sv
// Issue/control bundle between the issue stage, vec_ctrl_seq and the lane datapath/memory port.
// The master side is issue/memory; the slave side is the sequencer.
interface vec_ctrl_seq_if #(
  parameter int OPW = 5,
  parameter int BW  = 1
);
  logic           instr_valid;
  logic           instr_ready;
  logic [OPW-1:0] opcode;
  logic           flush;
  logic           mem_ack;
  logic [3:0]     aluop;
  logic           memread;
  logic           memwrite;
  logic           memtoreg;
  logic           regwrite;
  logic           jump;
  logic           beat_valid;
  logic [BW-1:0]  beat_idx;
  logic           beat_last;
  logic           busy;

  modport master (
    output instr_valid, opcode, flush, mem_ack,
    input  instr_ready, aluop, memread, memwrite, memtoreg, regwrite, jump,
           beat_valid, beat_idx, beat_last, busy
  );

  modport slave (
    input  instr_valid, opcode, flush, mem_ack,
    output instr_ready, aluop, memread, memwrite, memtoreg, regwrite, jump,
           beat_valid, beat_idx, beat_last, busy
  );
endinterface

// File: rtl/vec_ctrl_seq.sv
// Multi-beat vector control sequencer: decodes one opcode per handshake and steps it over BEATS beats.
// Optional macro VCTRL_ILLEGAL_EN adds the 'illegal' pulse output for undefined opcodes.
module vec_ctrl_seq #(
  parameter int OPW   = 5,
  parameter int VLEN  = 4,
  parameter int LANES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  vec_ctrl_seq_if.slave  bus
`ifdef VCTRL_ILLEGAL_EN
  ,
  output logic           illegal
`endif
);
  localparam int BEATS = VLEN / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(BEATS - 1);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_CMPJ = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_EORV = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP_SUBV = OPW'(5'b01001);
  localparam logic [OPW-1:0] OP_ADDV = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_LSLV = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_LSRV = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_RORV = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_ROLV = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_LDV  = OPW'(5'b10001);
  localparam logic [OPW-1:0] OP_STV  = OPW'(5'b10010);

  typedef enum logic [1:0] {S_IDLE, S_ALU, S_MEM} state_e;
  typedef enum logic [1:0] {CL_NONE, CL_ONE, CL_VEC, CL_MEM} cls_e;

  typedef struct packed {
    logic [3:0] aluop;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       wr;
    logic       jump;
    cls_e       cls;
  } dec_t;

  // Undefined opcodes fall through to the nop decode.
  function automatic dec_t decode(input logic [OPW-1:0] op);
    dec_t d;
    d     = '0;
    d.cls = CL_NONE;
    case (op)
      OP_ADD:  begin d.aluop = 4'b0000; d.wr = 1'b1; d.cls = CL_ONE; end
      OP_CMPJ: begin d.aluop = 4'b0001; d.wr = 1'b1; d.jump = 1'b1; d.cls = CL_ONE; end
      OP_EORV: begin d.aluop = 4'b0010; d.wr = 1'b1; d.cls = CL_VEC; end
      OP_SUBV: begin d.aluop = 4'b0001; d.wr = 1'b1; d.cls = CL_VEC; end
      OP_ADDV: begin d.aluop = 4'b0000; d.wr = 1'b1; d.cls = CL_VEC; end
      OP_LSLV: begin d.aluop = 4'b0011; d.wr = 1'b1; d.cls = CL_VEC; end
      OP_LSRV: begin d.aluop = 4'b0100; d.wr = 1'b1; d.cls = CL_VEC; end
      OP_RORV: begin d.aluop = 4'b0101; d.wr = 1'b1; d.cls = CL_VEC; end
      OP_ROLV: begin d.aluop = 4'b0110; d.wr = 1'b1; d.cls = CL_VEC; end
      OP_LDV:  begin d.memread = 1'b1; d.memtoreg = 1'b1; d.cls = CL_MEM; end
      OP_STV:  begin d.memwrite = 1'b1; d.cls = CL_MEM; end
      default: d.cls = CL_NONE;
    endcase
    return d;
  endfunction

  state_e         state_r, state_n;
  logic [OPW-1:0] op_r, op_n;
  logic [BW-1:0]  beat_idx_r, beat_n;
  logic [BW-1:0]  last_idx_r, last_idx_n;
  logic           last_n;
  dec_t           dec_n;
  logic [3:0]     aluop_r;
  logic           memread_r, memwrite_r, memtoreg_r, wr_r, jump_r;
  logic           valid_r, last_r;
  logic           advance_s, accept_s;

  // A beat retires every cycle in ALU, and only on mem_ack in MEM.
  assign advance_s = (state_r == S_ALU) | ((state_r == S_MEM) & bus.mem_ack);
  assign bus.instr_ready = ~bus.flush & ((state_r == S_IDLE) | (last_r & advance_s));
  assign accept_s  = bus.instr_valid & bus.instr_ready;

  // Next-state, beat counter and opcode capture; flush overrides accept and mem_ack.
  always_comb begin
    state_n    = state_r;
    op_n       = op_r;
    beat_n     = beat_idx_r;
    last_idx_n = last_idx_r;
    if (bus.flush) begin
      state_n = S_IDLE;
      beat_n  = '0;
    end else if (accept_s) begin
      op_n   = bus.opcode;
      beat_n = '0;
    end else if (advance_s) begin
      if (last_r) begin
        state_n = S_IDLE;
        beat_n  = '0;
      end else begin
        beat_n = beat_idx_r + BW'(1);
      end
    end else begin
      state_n = state_r;
    end
    dec_n = decode(op_n);
    if (accept_s) begin
      case (dec_n.cls)
        CL_ONE:  begin state_n = S_ALU;  last_idx_n = '0;       end
        CL_VEC:  begin state_n = S_ALU;  last_idx_n = LAST_IDX; end
        CL_MEM:  begin state_n = S_MEM;  last_idx_n = LAST_IDX; end
        default: begin state_n = S_IDLE; last_idx_n = '0;       end
      endcase
    end else begin
      last_idx_n = last_idx_n;
    end
    last_n = (state_n != S_IDLE) && (beat_n == last_idx_n);
  end

  // State, beat and registered control outputs (zero whenever no beat is active).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      op_r       <= '0;
      beat_idx_r <= '0;
      last_idx_r <= '0;
      aluop_r    <= 4'b0000;
      memread_r  <= 1'b0;
      memwrite_r <= 1'b0;
      memtoreg_r <= 1'b0;
      wr_r       <= 1'b0;
      jump_r     <= 1'b0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      op_r       <= op_n;
      beat_idx_r <= beat_n;
      last_idx_r <= last_idx_n;
      last_r     <= last_n;
      valid_r    <= (state_n != S_IDLE);
      if (state_n != S_IDLE) begin
        aluop_r    <= dec_n.aluop;
        memread_r  <= dec_n.memread;
        memwrite_r <= dec_n.memwrite;
        memtoreg_r <= dec_n.memtoreg;
        wr_r       <= dec_n.wr;
        jump_r     <= dec_n.jump;
      end else begin
        aluop_r    <= 4'b0000;
        memread_r  <= 1'b0;
        memwrite_r <= 1'b0;
        memtoreg_r <= 1'b0;
        wr_r       <= 1'b0;
        jump_r     <= 1'b0;
      end
    end
  end

  assign bus.aluop      = aluop_r;
  assign bus.memread    = memread_r;
  assign bus.memwrite   = memwrite_r;
  assign bus.memtoreg   = memtoreg_r;
  // Loads write back only in the beat where memory returns data.
  assign bus.regwrite   = wr_r | (memread_r & bus.mem_ack);
  assign bus.jump       = jump_r;
  assign bus.beat_valid = valid_r;
  assign bus.beat_idx   = beat_idx_r;
  assign bus.beat_last  = last_r;
  assign bus.busy       = (state_r != S_IDLE);

`ifdef VCTRL_ILLEGAL_EN
  function automatic logic is_legal(input logic [OPW-1:0] op);
    logic ok;
    case (op)
      OPW'(5'b00000), OP_ADD, OP_CMPJ, OP_EORV, OP_SUBV, OP_ADDV, OP_LSLV,
      OP_LSRV, OP_RORV, OP_ROLV, OP_LDV, OP_STV: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic illegal_r;

  // One-cycle pulse following the accept of an undefined opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= accept_s & ~is_legal(bus.opcode);
    end
  end

  assign illegal = illegal_r;
`endif
endmodule

// File: tb/tb_vec_ctrl_seq.sv
// Directed bench for vec_ctrl_seq (VLEN=4, LANES=2 -> 2 beats); inputs change and outputs are checked at negedge.
module tb_vec_ctrl_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vec_ctrl_seq_if #(.OPW(5), .BW(1)) bus ();
`ifdef VCTRL_ILLEGAL_EN
  logic illegal;
`endif

  vec_ctrl_seq #(.OPW(5), .VLEN(4), .LANES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef VCTRL_ILLEGAL_EN
    ,
    .illegal (illegal)
`endif
  );

  logic [4:0] vops [7] = '{5'b01000, 5'b01001, 5'b01010, 5'b01100, 5'b01101, 5'b01110, 5'b01111};
  logic [3:0] valu [7] = '{4'b0010, 4'b0001, 4'b0000, 4'b0011, 4'b0100, 4'b0101, 4'b0110};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {beat_valid, beat_idx, beat_last, aluop, memread, memwrite, memtoreg, regwrite, jump, busy}
  function automatic logic [31:0] obs();
    return {19'd0, bus.beat_valid, bus.beat_idx, bus.beat_last, bus.aluop, bus.memread,
            bus.memwrite, bus.memtoreg, bus.regwrite, bus.jump, bus.busy};
  endfunction

  function automatic logic [31:0] ev(input logic bv, input logic idx, input logic last,
                                     input logic [3:0] alu, input logic mr, input logic mw,
                                     input logic mt, input logic rw, input logic j, input logic bsy);
    return {19'd0, bv, idx, last, alu, mr, mw, mt, rw, j, bsy};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [4:0] op);
    bus.instr_valid = 1'b1;
    bus.opcode      = op;
    settle();
    check("ready_at_issue", 32'(bus.instr_ready), 32'd1);
    tick();
    bus.instr_valid = 1'b0;
    bus.opcode      = 5'b00000;
    settle();
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.opcode      = 5'b00000;
    bus.flush       = 1'b0;
    bus.mem_ack     = 1'b0;
    @(negedge clk);
    settle();
    check("reset_outputs", obs(), 32'd0);
    check("reset_ready", 32'(bus.instr_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // mem_ack in IDLE must not create a write
    bus.mem_ack = 1'b1;
    settle();
    check("ack_idle_ignored", obs(), 32'd0);
    bus.mem_ack = 1'b0;

    // addv: two beats, beat_last on idx 1, no bubble on ready
    issue(5'b01010);
    check("addv_b0", obs(), ev(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    tick();
    check("addv_b1", obs(), ev(1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    check("addv_ready_last", 32'(bus.instr_ready), 32'd1);
    tick();
    check("addv_idle", obs(), 32'd0);

    // ldv with acks on cycles 3 and 6 after accept
    issue(5'b10001);
    check("ldv_c1", obs(), ev(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    check("ldv_c1_ready", 32'(bus.instr_ready), 32'd0);
    tick();
    check("ldv_c2", obs(), ev(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tick();
    bus.mem_ack = 1'b1;
    settle();
    check("ldv_c3_ack", obs(), ev(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    tick();
    bus.mem_ack = 1'b0;
    settle();
    check("ldv_c4", obs(), ev(1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tick();
    check("ldv_c5", obs(), ev(1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tick();
    bus.mem_ack = 1'b1;
    settle();
    check("ldv_c6_ack", obs(), ev(1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    tick();
    bus.mem_ack = 1'b0;
    settle();
    check("ldv_idle", obs(), 32'd0);

    // stv then rolv back-to-back on the final ack
    issue(5'b10010);
    check("stv_b0", obs(), ev(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    bus.mem_ack = 1'b1;
    settle();
    check("stv_ack_nowr", obs(), ev(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    check("stv_b1", obs(), ev(1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    issue(5'b01111);
    bus.mem_ack = 1'b0;
    settle();
    check("rolv_b0", obs(), ev(1'b1, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    tick();
    check("rolv_b1", obs(), ev(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    tick();
    check("rolv_idle", obs(), 32'd0);

    // single-beat ops
    issue(5'b00110);
    check("cmpj_b0", obs(), ev(1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    tick();
    check("cmpj_idle", obs(), 32'd0);
    issue(5'b00100);
    check("add_b0", obs(), ev(1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    tick();
    check("add_idle", obs(), 32'd0);

    // all vector ALU ops decode and take two beats
    for (int i = 0; i < 7; i++) begin
      issue(vops[i]);
      check("vop_b0", obs(), ev(1'b1, 1'b0, 1'b0, valu[i], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      tick();
      check("vop_b1", obs(), ev(1'b1, 1'b1, 1'b1, valu[i], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      tick();
    end
    check("vop_idle", obs(), 32'd0);

    // flush during beat 0 of subv, with a competing addv offered
    issue(5'b01001);
    check("subv_b0", obs(), ev(1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    bus.flush       = 1'b1;
    bus.instr_valid = 1'b1;
    bus.opcode      = 5'b01010;
    settle();
    check("flush_ready", 32'(bus.instr_ready), 32'd0);
    tick();
    bus.flush       = 1'b0;
    bus.instr_valid = 1'b0;
    bus.opcode      = 5'b00000;
    settle();
    check("flush_outputs", obs(), 32'd0);
    check("flush_ready_after", 32'(bus.instr_ready), 32'd1);
    tick();
    check("flush_not_accepted", obs(), 32'd0);

    // async reset during beat 1 of addv
    issue(5'b01010);
    tick();
    check("rst_pre_b1", obs(), ev(1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", obs(), 32'd0);
    check("rst_mid_ready", 32'(bus.instr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    issue(5'b01010);
    check("post_rst_addv_b0", obs(), ev(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    tick();
    tick();

    // nop and undefined opcode: accepted, no beats
    issue(5'b00000);
    check("nop_idle", obs(), 32'd0);
    issue(5'b11111);
    check("undef_no_beat", obs(), 32'd0);
`ifdef VCTRL_ILLEGAL_EN
    check("illegal_pulse", 32'(illegal), 32'd1);
    tick();
    check("illegal_clear", 32'(illegal), 32'd0);
`endif
    tick();
    check("undef_stays_idle", obs(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
